// File: rtl/bus_target_decoder.sv
// Bus responder: latches one master request, forwards it to one of four targets and returns a registered ready.
// Optional dead-target timeout is enabled by defining BUS_TARGET_TIMEOUT_EN.
module bus_target_decoder #(
  parameter int unsigned SEL_LSB        = 28,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_RDATA    = 32'hDEADBEEF
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_bus_rw,
  input  logic          i_bus_request,
  output logic          o_bus_ready,
  input  logic [31:0]   i_bus_address,
  output logic [31:0]   o_bus_rdata,
  input  logic [31:0]   i_bus_wdata,
  output logic          o_bus_error,
  output logic [3:0]    o_t_request,
  output logic          o_t_rw,
  output logic [31:0]   o_t_address,
  output logic [31:0]   o_t_wdata,
  input  logic [3:0]    i_t_ready,
  input  logic [127:0]  i_t_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t        state_r, state_nxt_s;
  logic [1:0]    sel_r, sel_nxt_s;
  logic          ready_r, ready_nxt_s;
  logic          error_r, error_nxt_s;
  logic [31:0]   rdata_r, rdata_nxt_s;
  logic [3:0]    t_request_r, t_request_nxt_s;
  logic          t_rw_r, t_rw_nxt_s;
  logic [31:0]   t_address_r, t_address_nxt_s;
  logic [31:0]   t_wdata_r, t_wdata_nxt_s;
  logic          sel_ready_s;
  logic [6:0]    lane_base_s;
  logic [31:0]   sel_rdata_s;
  logic          timeout_s;

  assign sel_ready_s = i_t_ready[sel_r];
  assign lane_base_s = {sel_r, 5'd0};
  assign sel_rdata_s = i_t_rdata[lane_base_s +: 32];

`ifdef BUS_TARGET_TIMEOUT_EN
  logic [15:0] timer_r;

  assign timeout_s = (timer_r == TIMER_LAST);

  // Access-cycle timer: cleared on acceptance, counts ACCESS cycles without target ready.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && i_bus_request) begin
      timer_r <= 16'd0;
    end else if ((state_r == ST_ACCESS) && !sel_ready_s) begin
      timer_r <= timer_r + 16'd1;
    end else begin
      timer_r <= timer_r;
    end
  end
`else
  logic cfg_unused_s;

  assign timeout_s    = 1'b0;
  assign cfg_unused_s = ^TIMER_LAST;
`endif

  // State and registered-output storage.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      sel_r       <= 2'd0;
      ready_r     <= 1'b0;
      error_r     <= 1'b0;
      rdata_r     <= 32'd0;
      t_request_r <= 4'd0;
      t_rw_r      <= 1'b0;
      t_address_r <= 32'd0;
      t_wdata_r   <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      ready_r     <= ready_nxt_s;
      error_r     <= error_nxt_s;
      rdata_r     <= rdata_nxt_s;
      t_request_r <= t_request_nxt_s;
      t_rw_r      <= t_rw_nxt_s;
      t_address_r <= t_address_nxt_s;
      t_wdata_r   <= t_wdata_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_bus_request) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (sel_ready_s || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; ready takes priority over timeout.
  always_comb begin
    sel_nxt_s       = sel_r;
    ready_nxt_s     = ready_r;
    error_nxt_s     = error_r;
    rdata_nxt_s     = rdata_r;
    t_request_nxt_s = t_request_r;
    t_rw_nxt_s      = t_rw_r;
    t_address_nxt_s = t_address_r;
    t_wdata_nxt_s   = t_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (i_bus_request) begin
          sel_nxt_s       = i_bus_address[SEL_LSB +: 2];
          t_request_nxt_s = 4'b0001 << i_bus_address[SEL_LSB +: 2];
          t_rw_nxt_s      = i_bus_rw;
          t_address_nxt_s = i_bus_address;
          t_wdata_nxt_s   = i_bus_wdata;
        end else begin
          t_request_nxt_s = 4'd0;
        end
      end
      ST_ACCESS: begin
        if (sel_ready_s) begin
          t_request_nxt_s = 4'd0;
          ready_nxt_s     = 1'b1;
          rdata_nxt_s     = t_rw_r ? 32'd0 : sel_rdata_s;
        end else if (timeout_s) begin
          t_request_nxt_s = 4'd0;
          ready_nxt_s     = 1'b1;
          error_nxt_s     = 1'b1;
          rdata_nxt_s     = t_rw_r ? 32'd0 : ERROR_RDATA;
        end else begin
          ready_nxt_s     = 1'b0;
        end
      end
      ST_DONE: begin
        ready_nxt_s = 1'b0;
        error_nxt_s = 1'b0;
      end
      default: begin
        ready_nxt_s     = 1'b0;
        error_nxt_s     = 1'b0;
        t_request_nxt_s = 4'd0;
      end
    endcase
  end

  assign o_bus_ready = ready_r;
  assign o_bus_error = error_r;
  assign o_bus_rdata = rdata_r;
  assign o_t_request = t_request_r;
  assign o_t_rw      = t_rw_r;
  assign o_t_address = t_address_r;
  assign o_t_wdata   = t_wdata_r;

endmodule

// File: tb/tb_bus_target_decoder.sv
// Directed self-checking bench for bus_target_decoder; timeout steps run only with BUS_TARGET_TIMEOUT_EN.
module tb_bus_target_decoder;

  logic          clk;
  logic          rst_n;
  logic          bus_rw;
  logic          bus_request;
  logic          bus_ready;
  logic [31:0]   bus_address;
  logic [31:0]   bus_rdata;
  logic [31:0]   bus_wdata;
  logic          bus_error;
  logic [3:0]    t_request;
  logic          t_rw;
  logic [31:0]   t_address;
  logic [31:0]   t_wdata;
  logic [3:0]    t_ready;
  logic [127:0]  t_rdata;

  int checks;
  int failures;

  bus_target_decoder #(
    .SEL_LSB        (28),
    .TIMEOUT_CYCLES (8),
    .ERROR_RDATA    (32'hDEADBEEF)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_bus_rw      (bus_rw),
    .i_bus_request (bus_request),
    .o_bus_ready   (bus_ready),
    .i_bus_address (bus_address),
    .o_bus_rdata   (bus_rdata),
    .i_bus_wdata   (bus_wdata),
    .o_bus_error   (bus_error),
    .o_t_request   (t_request),
    .o_t_rw        (t_rw),
    .o_t_address   (t_address),
    .o_t_wdata     (t_wdata),
    .i_t_ready     (t_ready),
    .i_t_rdata     (t_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus_request = 1'b1;
    bus_rw = 1'b0;
    bus_address = 32'h0000_0020;
    bus_wdata = 32'h0;
    t_ready = 4'b0000;
    t_rdata = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'h0000_00A0};

    // 1: reset with request held
    #12;
    check("rst_t_request", {28'd0, t_request}, 32'd0);
    check("rst_ready", {31'd0, bus_ready}, 32'd0);
    check("rst_error", {31'd0, bus_error}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_t_rw", {31'd0, t_rw}, 32'd0);
    check("rst_t_address", t_address, 32'd0);
    check("rst_t_wdata", t_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_t_request", {28'd0, t_request}, 32'h1);
    check("post_rst_t_address", t_address, 32'h0000_0020);
    t_ready = 4'b0001;
    tick();
    check("post_rst_ready", {31'd0, bus_ready}, 32'd1);
    check("post_rst_rdata", bus_rdata, 32'h0000_00A0);
    bus_request = 1'b0;
    t_ready = 4'b0000;
    tick();
    check("post_rst_done", {31'd0, bus_ready}, 32'd0);

    // 2: zero-wait read from target 2
    t_rdata[95:64] = 32'hCAFE0002;
    bus_address = 32'h2000_0010;
    bus_request = 1'b1;
    t_ready = 4'b0100;
    tick();
    check("rd2_t_request", {28'd0, t_request}, 32'h4);
    check("rd2_ready_early", {31'd0, bus_ready}, 32'd0);
    tick();
    check("rd2_ready", {31'd0, bus_ready}, 32'd1);
    check("rd2_rdata", bus_rdata, 32'hCAFE0002);
    check("rd2_t_request_drop", {28'd0, t_request}, 32'h0);
    check("rd2_error", {31'd0, bus_error}, 32'd0);
    bus_request = 1'b0;
    tick();
    check("rd2_ready_pulse", {31'd0, bus_ready}, 32'd0);
    check("rd2_rdata_hold", bus_rdata, 32'hCAFE0002);
    tick();
    check("rd2_idle", {28'd0, t_request}, 32'h0);

    // 3: write to target 1 with 5 wait cycles, master changes inputs mid-access
    t_ready = 4'b0000;
    bus_address = 32'h1000_0004;
    bus_wdata = 32'h1234_5678;
    bus_rw = 1'b1;
    bus_request = 1'b1;
    tick();
    check("wr1_t_request", {28'd0, t_request}, 32'h2);
    bus_wdata = 32'hFFFF_0000;
    bus_rw = 1'b0;
    bus_address = 32'h3000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wr1_wait_t_request", {28'd0, t_request}, 32'h2);
      check("wr1_wait_t_wdata", t_wdata, 32'h1234_5678);
      check("wr1_wait_t_rw", {31'd0, t_rw}, 32'd1);
      check("wr1_wait_t_address", t_address, 32'h1000_0004);
      check("wr1_wait_ready", {31'd0, bus_ready}, 32'd0);
    end
    t_ready = 4'b0010;
    tick();
    check("wr1_ready", {31'd0, bus_ready}, 32'd1);
    check("wr1_rdata_zero", bus_rdata, 32'd0);
    bus_request = 1'b0;
    tick();
    check("wr1_ready_pulse", {31'd0, bus_ready}, 32'd0);
    t_ready = 4'b0000;

    // 4: stray readies on unselected targets, request dropped mid-access
    bus_rw = 1'b0;
    bus_address = 32'h2000_0100;
    bus_request = 1'b1;
    tick();
    check("stray_t_request", {28'd0, t_request}, 32'h4);
    bus_address = 32'h0000_0000;
    bus_request = 1'b0;
    t_ready = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_no_ready", {31'd0, bus_ready}, 32'd0);
      check("stray_t_request_held", {28'd0, t_request}, 32'h4);
      check("stray_t_address", t_address, 32'h2000_0100);
    end
    t_rdata[95:64] = 32'h0BAD_F00D;
    t_ready = 4'b0100;
    tick();
    check("stray_ready", {31'd0, bus_ready}, 32'd1);
    check("stray_rdata", bus_rdata, 32'h0BAD_F00D);
    tick();
    check("stray_ready_pulse", {31'd0, bus_ready}, 32'd0);
    t_ready = 4'b0000;
    tick();

`ifdef BUS_TARGET_TIMEOUT_EN
    // 5a: dead target 0 times out after 8 ACCESS cycles
    bus_address = 32'h0000_0040;
    bus_request = 1'b1;
    tick();
    check("to_t_request", {28'd0, t_request}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait_t_request", {28'd0, t_request}, 32'h1);
      check("to_wait_ready", {31'd0, bus_ready}, 32'd0);
    end
    tick();
    check("to_ready", {31'd0, bus_ready}, 32'd1);
    check("to_error", {31'd0, bus_error}, 32'd1);
    check("to_rdata", bus_rdata, 32'hDEADBEEF);
    check("to_t_request_drop", {28'd0, t_request}, 32'h0);
    bus_request = 1'b0;
    tick();
    check("to_error_pulse", {31'd0, bus_error}, 32'd0);
    tick();

    // 5b: ready arriving on the expiry cycle wins
    bus_request = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    t_ready = 4'b0001;
    tick();
    check("to_race_ready", {31'd0, bus_ready}, 32'd1);
    check("to_race_error", {31'd0, bus_error}, 32'd0);
    check("to_race_rdata", bus_rdata, 32'h0000_00A0);
    bus_request = 1'b0;
    t_ready = 4'b0000;
    tick();
    tick();
`endif

    // 6: async reset mid-ACCESS
    bus_address = 32'h3000_0008;
    bus_request = 1'b1;
    tick();
    check("arst_t_request_pre", {28'd0, t_request}, 32'h8);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_t_request", {28'd0, t_request}, 32'h0);
    check("arst_t_address", t_address, 32'h0);
    tick();
    check("arst_no_ready", {31'd0, bus_ready}, 32'd0);
    rst_n = 1'b1;
    t_rdata[127:96] = 32'h3333_0003;
    t_ready = 4'b1000;
    tick();
    check("arst_next_t_request", {28'd0, t_request}, 32'h8);
    tick();
    check("arst_next_ready", {31'd0, bus_ready}, 32'd1);
    check("arst_next_rdata", bus_rdata, 32'h3333_0003);
    check("arst_next_error", {31'd0, bus_error}, 32'd0);
    bus_request = 1'b0;
    tick();
    check("arst_next_pulse", {31'd0, bus_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
